// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a latency-configurable multiplier and an iterative restoring divider.
// mthi/mtlo complete in one cycle; mult/div run multi-cycle behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready; accepts mthi/mtlo (single cycle) or starts mult/div
// MUL   | multiplier latency countdown; writes {hi,lo} when the counter reaches zero
// DIV   | restoring division, one quotient bit per clock
// FIN   | applies sign correction and writes the quotient/remainder to lo/hi
module hilo_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_mult,
    input  logic             is_multu,
    input  logic             is_div,
    input  logic             is_divu,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a, op_b, quot, rem;
    logic               sign_q, sign_r, div_zero;

    logic               sgn_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH:0]     shifted, diff;

    always_comb begin
        // div beats divu beats mult beats multu when strobes overlap
        sgn_in   = is_div | (~is_divu & is_mult);
        mag_a    = (sgn_in && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b    = (sgn_in && src_b[WIDTH-1]) ? -src_b : src_b;
        prod_mag = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        prod     = sign_q ? -prod_mag : prod_mag;
        shifted  = {rem, quot[WIDTH-1]};
        diff     = shifted - {1'b0, op_b};
    end

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            quot     <= '0;
            rem      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !cancel) begin
                        if (is_div || is_divu) begin
                            op_a     <= mag_a;
                            op_b     <= mag_b;
                            quot     <= mag_a;
                            rem      <= '0;
                            sign_q   <= sgn_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            sign_r   <= sgn_in & src_a[WIDTH-1];
                            div_zero <= (src_b == '0);
                            cnt      <= '0;
                            state    <= DIV;
                        end else if (is_mult || is_multu) begin
                            op_a   <= mag_a;
                            op_b   <= mag_b;
                            sign_q <= sgn_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            cnt    <= CW'(MUL_LAT - 1);
                            state  <= MUL;
                        end else begin
                            if (hi_wen) hi <= src_a;
                            if (lo_wen) lo <= src_a;
                        end
                    end
                end
                MUL: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        {hi, lo} <= prod;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        if (!diff[WIDTH]) begin
                            rem  <= diff[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= shifted[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                        if (cnt == CW'(WIDTH - 1)) state <= FIN;
                        else cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        // divide by zero returns the raw dividend, rebuilt from its magnitude
                        if (div_zero) begin
                            lo <= '1;
                            hi <= sign_r ? -op_a : op_a;
                        end else begin
                            lo <= sign_q ? -quot : quot;
                            hi <= sign_r ? -rem : rem;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table for single operations plus
// hand-written sequences for back-to-back, cancel, reset and held-off requests.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_mult = 1'b0, is_multu = 1'b0, is_div = 1'b0, is_divu = 1'b0;
    logic        hi_wen = 1'b0, lo_wen = 1'b0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    hilo_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // sel = {is_div, is_divu, is_mult, is_multu, hi_wen, lo_wen}
    localparam logic [5:0] S_DIV = 6'b100000, S_DIVU = 6'b010000, S_MULT = 6'b001000,
                           S_MULTU = 6'b000100, S_HI = 6'b000010, S_LO = 6'b000001;

    typedef struct {
        logic [5:0]  sel;
        logic [31:0] a, b, exp_hi, exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = 1'b0;
        {is_div, is_divu, is_mult, is_multu, hi_wen, lo_wen} = 6'b0;
        cancel = 1'b0;
    endtask

    task automatic start(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        {is_div, is_divu, is_mult, is_multu, hi_wen, lo_wen} = sel;
        src_a = a;
        src_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n;
    int seen;

    initial begin
        vecs[0]  = '{S_HI,          32'h11111111, 32'h0,        32'h11111111, 32'h00000000, 0};
        vecs[1]  = '{S_LO,          32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 0};
        vecs[2]  = '{S_HI | S_LO,   32'h00000033, 32'h0,        32'h00000033, 32'h00000033, 0};
        vecs[3]  = '{S_MULT,        32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2};
        vecs[4]  = '{S_MULTU,       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
        vecs[5]  = '{S_MULT,        32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 2};
        vecs[6]  = '{S_MULT | S_HI, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 2};
        vecs[7]  = '{S_DIV,         32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[8]  = '{S_DIV,         32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[9]  = '{S_DIVU,        32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 33};
        vecs[10] = '{S_DIV,         32'hFFFFFFF8, 32'h0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33};
        vecs[11] = '{S_DIVU,        32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vecs[12] = '{S_DIV,         32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[13] = '{S_DIV | S_MULT, 32'd20,      32'd3,        32'h00000002, 32'h00000006, 33};

        // reset state
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start(vecs[i].sel, vecs[i].a, vecs[i].b);
            if (vecs[i].lat == 0) begin
                chk($sformatf("v%0d_no_done", i), done, 0);
                chk($sformatf("v%0d_ready", i), in_ready, 1);
            end else begin
                chk($sformatf("v%0d_busy", i), busy, 1);
                wait_done(n);
                chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
                chk($sformatf("v%0d_ready_at_done", i), in_ready, 1);
            end
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            if (vecs[i].lat != 0) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_done_pulse", i), done, 0);
            end
        end

        // back-to-back mthi in the done cycle of a multu
        start(S_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        chk("b2b_latency", n, 2);
        in_valid = 1'b1;
        hi_wen = 1'b1;
        src_a = 32'h55;
        @(posedge clk);
        #1;
        clear_in();
        chk("b2b_hi", hi, 32'h55);
        chk("b2b_lo", lo, 32'h1);
        chk("b2b_no_done", done, 0);

        // mtlo requested while busy is held off, then taken on the first ready cycle
        start(S_MULT, 32'd6, 32'd7);
        in_valid = 1'b1;
        lo_wen = 1'b1;
        src_a = 32'h77;
        @(posedge clk);
        #1;
        chk("holdoff_lo_e1", lo, 32'h1);
        chk("holdoff_busy_e1", busy, 1);
        @(posedge clk);
        #1;
        chk("holdoff_done_e2", done, 1);
        chk("holdoff_lo_e2", lo, 32'h2A);
        @(posedge clk);
        #1;
        clear_in();
        chk("holdoff_lo_e3", lo, 32'h77);
        chk("holdoff_hi_e3", hi, 32'h0);

        // cancel mid-divide
        start(S_HI | S_LO, 32'hA5A5A5A5, 32'h0);
        start(S_DIV, 32'hFFFFFFF9, 32'h2);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_ready", in_ready, 1);
        chk("cancel_hi", hi, 32'hA5A5A5A5);
        chk("cancel_lo", lo, 32'hA5A5A5A5);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("cancel_no_done", seen, 0);

        // cancel in IDLE blocks mtlo
        @(negedge clk);
        in_valid = 1'b1;
        lo_wen = 1'b1;
        cancel = 1'b1;
        src_a = 32'h1;
        @(posedge clk);
        #1;
        clear_in();
        chk("idle_cancel_lo", lo, 32'hA5A5A5A5);

        // asynchronous reset mid-divide
        start(S_DIV, 32'd100, 32'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_hi", hi, 0);
        chk("areset_lo", lo, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair. It sits beside the EX stage and is driven by the decoder's `is_mult`/`is_multu`/`is_div`/`is_divu`/`hi_wen`/`lo_wen` strobes. It replaces the single-cycle HI/LO path with an iterative divider, a latency-configurable multiplier, a valid/ready handshake and exception cancel. `hi`/`lo` feed the `mfhi`/`mflo` result mux directly.

## Interface
- `WIDTH`, 32: operand/HI/LO width; even, ≥ 8.
- `MUL_LAT`, 2: multiply latency in cycles, ≥ 1.

- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  reset; one clock; asynchronous, active-low.
- `in_valid`  in  1  EX holds a HI/LO-class instruction.
- `in_ready`  out  1  unit can accept; equals state == IDLE.
- `is_mult`, `is_multu`, `is_div`, `is_divu`  in  1 each  operation select.
- `hi_wen`, `lo_wen`  in  1 each  mthi/mtlo; write `src_a`.
- `src_a`, `src_b`  in  WIDTH each  rs / rt data.
- `cancel`  in  1  exception/ERET flush; aborts any accepted or in-flight op.
- `busy`  out  1  `~in_ready`.
- `done`  out  1  one-cycle pulse, the cycle after HI/LO update by mult/div.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- Accept = `in_valid & in_ready & ~cancel`. If several strobes are set, priority is div > divu > mult > multu > (hi_wen/lo_wen). `hi_wen` and `lo_wen` together are legal.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - accepted mthi/mtlo writes `hi`/`lo` at the accepting edge and stays in IDLE; no `done`.
  - accepted mult/multu latches operand magnitudes and result sign, loads counter = MUL_LAT−1, goes to MUL.
  - accepted div/divu latches magnitudes, quotient sign (`a[MSB]^b[MSB]`, signed only), remainder sign (`a[MSB]`, signed only) and a `b==0` flag, clears counter, goes to DIV.
- MUL: full 2·WIDTH-bit unsigned product of the latched magnitudes, negated when the sign is set. When counter == 0, {hi,lo} ← product and go to IDLE; else decrement.
- DIV: restoring radix-2, one quotient bit per edge, WIDTH edges, then FIN.
- FIN: apply sign corrections; lo ← quotient, hi ← remainder; go to IDLE.
  - Divide by zero skips sign correction: lo = all-ones, hi = `src_a` as latched.
  - Signed MIN / −1: lo = MIN, hi = 0 (natural result of the magnitude path).
- `cancel` in any non-IDLE state: next edge goes to IDLE, HI/LO untouched, no `done`. `cancel` in IDLE blocks acceptance, including mthi/mtlo.
- Reset (async, any state): state IDLE, hi = lo = 0, counter 0, `done` 0, all latched operands 0.

## Timing
- Accept at edge E0.
- mthi/mtlo: visible after E0; `in_ready` stays 1.
- mult: HI/LO updated at E(MUL_LAT); `in_ready` low for MUL_LAT cycles.
- div: HI/LO updated at E(WIDTH+1), i.e. E33 at WIDTH=32; `in_ready` low for WIDTH+1 cycles.
- `done` is registered: high during the cycle following the HI/LO-updating edge.
- `in_ready` reasserts in that same cycle. A back-to-back accept is legal there.
- `hi`/`lo` are direct register outputs. No forwarding from in-flight results; the pipeline stalls mfhi/mflo while `busy`.
- Counter width: $clog2(WIDTH+1).

## Test plan
- mult signed, a=0xFFFFFFFD (−3), b=5, MUL_LAT=2 -> at E2 hi=0xFFFFFFFF, lo=0xFFFFFFF1; `done` high one cycle after E2.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then a back-to-back mthi 0x55 in the `done` cycle -> hi=0x55 one edge later.
- div signed a=−7, b=2 -> `in_ready` low 33 cycles; at E33 lo=0xFFFFFFFD, hi=0xFFFFFFFF. div MIN/−1 -> lo=0x80000000, hi=0.
- divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. Signed div −8/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF8.
- Cancel: preload hi=lo=0xA5A5A5A5, start div, assert `cancel` at cycle 10 -> `in_ready`=1 next cycle; hi/lo remain 0xA5A5A5A5; no `done`. `in_valid`+`lo_wen`+`cancel` in IDLE -> lo unchanged.
- Reset mid-div (`resetn` low asynchronously at cycle 5) -> hi=lo=0, `busy`=0, `done`=0 immediately. Busy-period `in_valid` (mtlo) is held off by `in_ready`=0 and accepted on the first ready cycle.
